// File: rtl/if_fetch_unit.sv
// Fetch stage: assembles five imem words into one 160-bit bundle for IF/ID, 2 cycles/word at 1-cycle memory latency.
// Holds the bundle while staller is high; optional IF_NOP_FILL_EN shows five NOP_WORD while no bundle is valid.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         staller,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         bundle_valid,
    output logic [31:0]  PC_out,
    output logic [159:0] idata_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FULL  = 3'd4;

    logic [2:0]   r_state;
    logic [31:0]  r_fetch_pc;
    logic [2:0]   r_cnt;
    logic [31:0]  r_pc_out;
    logic [159:0] r_idata;
    logic [31:0]  r_asm [0:3];

    logic [31:0]  w_redir_pc;
    logic         w_store;
    logic         w_unused;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_store    = (r_state == S_WAIT) && imem_rvalid && !redirect;
    assign w_unused   = ^{redirect_pc[1:0], NOP_WORD};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_cnt      <= 3'd0;
            r_pc_out   <= RESET_PC;
            r_idata    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_cnt      <= 3'd0;
            case (r_state)
                S_REQ:   r_state <= S_DRAIN;
                // a response landing this cycle retires the outstanding read, so no drain is needed
                S_WAIT,
                S_DRAIN: r_state <= imem_rvalid ? S_REQ : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ:  r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_cnt == 3'd4) begin
                            r_state  <= S_FULL;
                            r_pc_out <= r_fetch_pc;
                            r_idata  <= {imem_rdata, r_asm[3], r_asm[2], r_asm[1], r_asm[0]};
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_FULL: begin
                    if (!staller) begin
                        r_fetch_pc <= r_fetch_pc + 32'd20;
                        r_cnt      <= 3'd0;
                        r_state    <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Word 4 goes straight to the output register, so only words 0..3 are buffered.
    always_ff @(posedge clk) begin
        if (w_store && (r_cnt != 3'd4)) begin
            r_asm[r_cnt[1:0]] <= imem_rdata;
        end
    end

    assign imem_req     = (r_state == S_REQ);
    assign imem_addr    = r_fetch_pc + {27'd0, r_cnt, 2'b00};
    assign bundle_valid = (r_state == S_FULL);
    assign PC_out       = r_pc_out;

`ifdef IF_NOP_FILL_EN
    assign idata_out = bundle_valid ? r_idata : {5{NOP_WORD}};
`else
    assign idata_out = r_idata;
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It generates the fetch PC and gathers five consecutive 32-bit instruction words from a single-word instruction-memory port into one 160-bit bundle. It then presents the bundle with its PC to IF/ID. It honours the pipeline `staller`, and a branch/jump redirect that discards in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: bundle PC fetched after reset. Low 2 bits must be 0.
- `NOP_WORD`, default 32'h0000_0013: filler instruction (`addi x0,x0,0`), used only with `IF_NOP_FILL_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `staller` in 1: downstream stall. While high, a presented bundle is held and not consumed.
- `redirect` in 1: one-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc` in 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: read request, one-cycle pulse, at most one outstanding.
- `imem_addr` out 32: word address of the request, valid when `imem_req`=1.
- `imem_rvalid` in 1: read data valid. Arrives at least 1 cycle after its request.
- `imem_rdata` in 32: read data.
- `bundle_valid` out 1: `PC_out`/`idata_out` hold a complete bundle.
- `PC_out` out 32: address of word 0 of the bundle.
- `idata_out` out 160: word k (address `PC_out`+4k) in bits [32k+31:32k], k=0..4.

## Operation
- State: `fetch_pc` (32), `cnt` (3 bits, 0..4), FSM {IDLE, REQ, WAIT, DRAIN, FULL}.
- IDLE: entered only via reset. Next cycle goes to REQ.
- REQ: `imem_req`=1, `imem_addr`=`fetch_pc`+4·`cnt`. Next state is WAIT.
- WAIT: on `imem_rvalid`, store `imem_rdata` into word `cnt`.
  - If `cnt`=4: go to FULL, `PC_out`←`fetch_pc`, `bundle_valid`←1.
  - Otherwise: `cnt`++ and go to REQ.
- FULL: `bundle_valid`=1. The bundle is consumed at a rising edge with `staller`=0.
  - On consumption: `fetch_pc`←`fetch_pc`+20 (mod 2^32), `cnt`←0, `bundle_valid`←0, next state REQ.
  - With `staller`=1: all outputs held.
- Word storage goes to an internal assembly buffer. `idata_out` is updated from it only on entry to FULL, so outputs never show a partial bundle.
- Redirect has priority over all other events except reset.
  - Effect: `fetch_pc`←{`redirect_pc`[31:2],2'b00}, `cnt`←0, `bundle_valid`←0.
  - From REQ or DRAIN: go to DRAIN, because a request is outstanding.
  - From WAIT without `imem_rvalid`: go to DRAIN.
  - From WAIT with `imem_rvalid` in the same cycle: the data is discarded and the FSM goes to REQ.
  - From FULL or IDLE: go to REQ. A redirect in FULL wins over consumption; `fetch_pc` does not advance by 20.
- DRAIN: `imem_req`=0. On `imem_rvalid`, discard the data and go to REQ.
- `imem_rvalid` is ignored in IDLE, REQ and FULL.
- Reset mid-operation: the FSM returns to IDLE and any outstanding response is dropped. The memory must not return data after reset.

## Timing
- Reset values:
  - `bundle_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `PC_out`=`RESET_PC`.
  - `idata_out`=0, or five `NOP_WORD` with `IF_NOP_FILL_EN`.
  - `fetch_pc`=`RESET_PC`, `cnt`=0, state IDLE.
- `imem_req`, `imem_addr` and `bundle_valid` are decoded from registered state only. There is no combinational path from any input to any output.
- With 1-cycle memory latency, each word takes 2 cycles (REQ, WAIT).
  - First `bundle_valid` comes 11 cycles after `rst_n` rises (IDLE + 5×2).
  - Steady-state throughput is one bundle per 11 cycles.
- After a redirect accepted in WAIT or FULL, the first request to the new target is issued in the next cycle (REQ).
- IF/ID captures `PC_out`/`idata_out` at the same edge where consumption occurs.

## Configuration
- `IF_NOP_FILL_EN` defined: while `bundle_valid`=0, `idata_out` reads as five `NOP_WORD` and `PC_out` holds its last value.
  - Use this because IF/ID has no valid bit, and unstalled bubbles must execute as NOPs.
- Not defined: `idata_out` holds the last completed bundle, or 0 after reset. Downstream must qualify with `bundle_valid`.

## Test plan
- Reset release with 1-cycle memory returning addr as data → `imem_addr` sequence 0,4,8,12,16. `bundle_valid` rises 11 cycles after reset. `PC_out`=0, `idata_out`={16,12,8,4,0}.
- `staller`=1 for 5 cycles while FULL → outputs stable and no `imem_req`. After release, the next request is at addr 20 and the next `PC_out`=20.
- `redirect`=1 with `redirect_pc`=0x103 while in WAIT at `cnt`=2, `imem_rvalid` low → DRAIN. The late response is discarded; the next request is at 0x100 and the bundle has `PC_out`=0x100.
- `redirect` in FULL with `staller`=0 in the same cycle → `bundle_valid`=0 next cycle. The next request is to the redirect target, not PC+20.
- `RESET_PC`=32'hFFFF_FFEC, one bundle consumed → next `fetch_pc` wraps to 0x0000_0000.
- Under `IF_NOP_FILL_EN`: between bundles, `idata_out`=5×32'h0000_0013. Without the macro it holds the previous bundle.
